// File: rtl/ysyx_22051468_mul_div_unit_if.sv
// rtl/ysyx_22051468_mul_div_unit_if.sv - EX-stage request/result bundle for the M-extension unit
interface ysyx_22051468_mul_div_unit_if #(
  parameter int WIDTH = 64
);
  logic             valid_i;
  logic [WIDTH-1:0] rs1_data_i;
  logic [WIDTH-1:0] rs2_data_i;
  logic             is_mul_i;
  logic             is_div_i;
  logic             is_rem_i;
  logic             is_U_i;
  logic             is_W_i;
  logic             mul_hi_i;
  logic             mul_su_i;
  logic             flush_i;
  logic             ready_i;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;

  modport slave (
    input  valid_i, rs1_data_i, rs2_data_i, is_mul_i, is_div_i, is_rem_i,
           is_U_i, is_W_i, mul_hi_i, mul_su_i, flush_i, ready_i,
    output busy_o, valid_o, result_o
  );

  modport master (
    output valid_i, rs1_data_i, rs2_data_i, is_mul_i, is_div_i, is_rem_i,
           is_U_i, is_W_i, mul_hi_i, mul_su_i, flush_i, ready_i,
    input  busy_o, valid_o, result_o
  );
endinterface

// File: rtl/ysyx_22051468_mul_div_unit.sv
// rtl/ysyx_22051468_mul_div_unit.sv - iterative radix-2 RV64M multiply/divide unit
// Sign-magnitude datapath: operands are made positive on accept, the sign is fixed up in DONE.
module ysyx_22051468_mul_div_unit #(
  parameter int WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ysyx_22051468_mul_div_unit_if.slave   io
);
  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               mul_q, mul_d;
  logic               div_q, div_d;
  logic               mhi_q, mhi_d;
  logic               w_q, w_d;
  logic               neg_q, neg_d;

  logic               su_op, sgn_a, sgn_b, neg_a, neg_b, div_op, div_zero, div_ovf;
  logic [WIDTH-1:0]   op_a, op_b, abs_a, abs_b, min_neg;
  logic [WIDTH:0]     mul_sum, div_tmp, div_diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, full_res, final_res;

  // MULHSU treats rs1 as signed and rs2 as unsigned regardless of is_U_i
  assign su_op  = io.is_mul_i & io.mul_hi_i & io.mul_su_i;
  assign sgn_a  = ~io.is_U_i | su_op;
  assign sgn_b  = ~io.is_U_i & ~su_op;
  assign op_a   = io.is_W_i ? {{HW{sgn_a & io.rs1_data_i[HW-1]}}, io.rs1_data_i[HW-1:0]}
                            : io.rs1_data_i;
  assign op_b   = io.is_W_i ? {{HW{sgn_b & io.rs2_data_i[HW-1]}}, io.rs2_data_i[HW-1:0]}
                            : io.rs2_data_i;
  assign neg_a  = sgn_a & op_a[WIDTH-1];
  assign neg_b  = sgn_b & op_b[WIDTH-1];
  assign abs_a  = neg_a ? -op_a : op_a;
  assign abs_b  = neg_b ? -op_b : op_b;

  assign div_op   = io.is_div_i | io.is_rem_i;
  assign min_neg  = io.is_W_i ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(WIDTH-1){1'b0}}};
  assign div_zero = div_op & (op_b == '0);
  assign div_ovf  = div_op & sgn_b & (op_a == min_neg) & (op_b == {WIDTH{1'b1}});

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign div_tmp  = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_tmp - {1'b0, a_q};

  // A W multiply stops after HW shifts, so its product sits HW bits up in {hi, lo}
  assign prod      = w_q ? {{HW{1'b0}}, hi_q, lo_q[WIDTH-1:HW]} : {hi_q, lo_q};
  assign prod_s    = neg_q ? -prod : prod;
  assign quo_s     = neg_q ? -lo_q : lo_q;
  assign rem_s     = neg_q ? -hi_q : hi_q;
  assign full_res  = mul_q ? (mhi_q ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0])
                           : (div_q ? quo_s : rem_s);
  assign final_res = w_q ? {{HW{full_res[HW-1]}}, full_res[HW-1:0]} : full_res;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    mul_d    = mul_q;
    div_d    = div_q;
    mhi_d    = mhi_q;
    w_d      = w_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        if (io.valid_i && !io.flush_i) begin
          mul_d = io.is_mul_i;
          div_d = io.is_div_i;
          mhi_d = io.mul_hi_i;
          w_d   = io.is_W_i;
          hi_d  = '0;
          cnt_d = io.is_W_i ? CW'(HW) : CW'(WIDTH);
          state_d = CALC;
          if (io.is_mul_i) begin
            a_d   = abs_a;
            lo_d  = abs_b;
            neg_d = neg_a ^ neg_b;
          end else if (div_zero) begin
            lo_d    = {WIDTH{1'b1}};
            hi_d    = op_a;
            neg_d   = 1'b0;
            state_d = DONE;
          end else if (div_ovf) begin
            lo_d    = op_a;
            neg_d   = 1'b0;
            state_d = DONE;
          end else begin
            a_d   = abs_b;
            lo_d  = io.is_W_i ? {abs_a[HW-1:0], {HW{1'b0}}} : abs_a;
            neg_d = io.is_div_i ? (neg_a ^ neg_b) : neg_a;
          end
        end
      end
      CALC: begin
        if (io.flush_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (mul_q) begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end else if (!div_diff[WIDTH]) begin
            hi_d = div_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_tmp[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == CW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        result_d = final_res;
        if (io.flush_i || io.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      mul_q    <= 1'b0;
      div_q    <= 1'b0;
      mhi_q    <= 1'b0;
      w_q      <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      mul_q    <= mul_d;
      div_q    <= div_d;
      mhi_q    <= mhi_d;
      w_q      <= w_d;
      neg_q    <= neg_d;
    end
  end

  assign io.busy_o   = ((state_q == IDLE) & io.valid_i & ~io.flush_i) | (state_q == CALC)
                     | ((state_q == DONE) & ~io.ready_i);
  assign io.valid_o  = (state_q == DONE);
  assign io.result_o = (state_q == DONE) ? final_res : result_q;
endmodule

// File: tb/tb_ysyx_22051468_mul_div_unit.sv
// tb/tb_ysyx_22051468_mul_div_unit.sv - directed-vector bench for the mul/div unit
module tb_ysyx_22051468_mul_div_unit;
  localparam int W = 64;
  // {is_mul, is_div, is_rem, is_U, is_W, mul_hi, mul_su}
  localparam logic [6:0] OP_MUL    = 7'b1000000;
  localparam logic [6:0] OP_MULH   = 7'b1000010;
  localparam logic [6:0] OP_MULHU  = 7'b1001010;
  localparam logic [6:0] OP_MULHSU = 7'b1000011;
  localparam logic [6:0] OP_MULW   = 7'b1000100;
  localparam logic [6:0] OP_DIV    = 7'b0100000;
  localparam logic [6:0] OP_DIVU   = 7'b0101000;
  localparam logic [6:0] OP_REM    = 7'b0010000;
  localparam logic [6:0] OP_REMU   = 7'b0011000;
  localparam logic [6:0] OP_DIVW   = 7'b0100100;
  localparam logic [6:0] OP_DIVUW  = 7'b0101100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ysyx_22051468_mul_div_unit_if #(.WIDTH(W)) bus ();

  ysyx_22051468_mul_div_unit #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] f, input logic [63:0] a, input logic [63:0] b);
    {bus.is_mul_i, bus.is_div_i, bus.is_rem_i, bus.is_U_i,
     bus.is_W_i, bus.mul_hi_i, bus.mul_su_i} = f;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
  endtask

  // Present one op, time valid_o from the accept cycle, optionally stall it in DONE.
  task automatic run_op(input string tag, input logic [6:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    bit busy_ok;
    @(negedge clk);
    bus.ready_i = (hold == 0);
    drive(f, a, b);
    bus.valid_i = 1'b1;
    #1 busy_ok = bus.busy_o;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    drive(7'b0, 64'h0, 64'h0);
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (bus.valid_o) break;
      if (!bus.busy_o) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
    end
    check({tag, "/result"}, bus.result_o, exp);
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/busy"}, 64'(busy_ok), 64'd1);
    for (int i = 0; i < hold; i++) begin
      check({tag, "/hold_result"}, bus.result_o, exp);
      check({tag, "/hold_busy"}, 64'(bus.busy_o), 64'd1);
      check({tag, "/hold_valid"}, 64'(bus.valid_o), 64'd1);
      @(posedge clk);
      @(negedge clk);
    end
    bus.ready_i = 1'b1;
    #1 check({tag, "/busy_done"}, 64'(bus.busy_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "/valid_clr"}, 64'(bus.valid_o), 64'd0);
    check({tag, "/result_keep"}, bus.result_o, exp);
  endtask

  initial begin
    bit saw;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    drive(7'b0, 64'h0, 64'h0);
    repeat (3) @(negedge clk);
    check("reset/valid", 64'(bus.valid_o), 64'd0);
    check("reset/busy", 64'(bus.busy_o), 64'd0);
    check("reset/result", bus.result_o, 64'd0);
    rst_n = 1'b1;

    run_op("mul", OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    run_op("mulhu", OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1, 65, 0);
    run_op("mulh", OP_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("mulhsu", OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("mulhsu2", OP_MULHSU, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 65, 0);
    run_op("mulhu_max", OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("div", OP_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65, 0);
    run_op("rem", OP_REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("divu", OP_DIVU, 64'd20, 64'd3, 64'd6, 65, 0);
    run_op("remu", OP_REMU, 64'd20, 64'd3, 64'd2, 65, 0);
    run_op("div0", OP_DIV, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("rem0", OP_REM, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    run_op("divuw", OP_DIVUW, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, 0);
    run_op("mulw", OP_MULW, 64'h1_0000_0002, 64'd3, 64'd6, 33, 0);
    run_op("divw", OP_DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
    run_op("hold", OP_DIVU, 64'd100, 64'd7, 64'd14, 65, 5);

    // flush at CALC cycle 10
    @(negedge clk);
    drive(OP_DIVU, 64'd1000, 64'd7);
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush/busy", 64'(bus.busy_o), 64'd0);
    check("flush/valid", 64'(bus.valid_o), 64'd0);
    saw = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (bus.valid_o) saw = 1'b1;
    end
    check("flush/no_result", 64'(saw), 64'd0);
    run_op("after_flush", OP_MUL, 64'd12, 64'd11, 64'd132, 65, 0);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    drive(OP_MUL, 64'd5, 64'd9);
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rst_mid/busy_before", 64'(bus.busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid/valid", 64'(bus.valid_o), 64'd0);
    check("rst_mid/busy", 64'(bus.busy_o), 64'd0);
    check("rst_mid/result", bus.result_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (bus.valid_o) saw = 1'b1;
    end
    check("rst_mid/no_result", 64'(saw), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22051468_mul_div_unit.md
Name: ysyx_22051468_mul_div_unit

Overview:
- Iterative radix-2 multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes rs1/rs2 data plus the is_mul/is_div/is_rem/is_U/is_W decode flags.
- Computes all RV64M results, including the W variants.
- Stalls the front of the pipeline through busy_o while an operation is in flight.

Parameters:
- WIDTH, 64, operand/result width (XLEN); W ops use the low WIDTH/2 bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_i  input  1  a M-extension op is present in EX this cycle.
- rs1_data_i  input  WIDTH  operand A (multiplicand/dividend).
- rs2_data_i  input  WIDTH  operand B (multiplier/divisor).
- is_mul_i  input  1  multiply class.
- is_div_i  input  1  divide (quotient).
- is_rem_i  input  1  remainder.
- is_U_i  input  1  unsigned variant (MULHU, DIVU, REMU, DIVUW, REMUW).
- is_W_i  input  1  32-bit word variant.
- mul_hi_i  input  1  multiply returns the upper WIDTH bits of the product (MULH*).
- mul_su_i  input  1  with mul_hi_i: MULHSU (rs1 signed, rs2 unsigned); overrides is_U_i.
- flush_i  input  1  abort any in-flight op.
- ready_i  input  1  downstream accepts the result this cycle.
- busy_o  output  1  hold request, OR-ed into hold_pipeline.
- valid_o  output  1  result_o is valid.
- result_o  output  WIDTH  result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, counter=0, all datapath registers 0.
  - valid_o=0, busy_o=0, result_o=0.
- Exactly one of is_mul_i/is_div_i/is_rem_i is high when valid_i is high. Flags are sampled only on the IDLE accept edge and latched internally; later input changes are ignored.
- States: IDLE, CALC, DONE.
- IDLE & valid_i & ~flush_i:
  - Latch operands. Take absolute values where the op is signed.
  - Record the result sign: mul = sA^sB; quotient = sA^sB; remainder = sA.
  - W ops: operands come from bits [31:0]. Signed ops sign-extend from bit 31; unsigned ops zero-extend. Iteration count is 32; otherwise 64.
  - Special divide cases go directly to DONE with the result preloaded:
    - Divide by zero: quotient = all ones; remainder = dividend.
    - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - All other ops go to CALC with counter = iteration count.
- CALC: one iteration per cycle; counter decrements; at counter==1 the next state is DONE.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, quotient bit shifted in and partial remainder kept.
- Latency: accept edge plus N CALC cycles, then valid_o in the following cycle.
  - Normal ops: valid_o first high 65 cycles after accept (33 for W ops).
  - Special cases: valid_o 1 cycle after accept.
- DONE:
  - Apply sign correction (two's complement negate if the sign flag is set).
  - Select the output:
    - mul_hi_i: upper half of the product.
    - Other multiplies: lower half.
    - is_div_i: quotient.
    - is_rem_i: remainder.
  - W ops: result_o = sign-extend of result[31:0]. This applies to DIVUW/REMUW as well.
  - valid_o=1. Stay in DONE while ready_i=0. On ready_i=1, go to IDLE the next edge.
- busy_o = (IDLE & valid_i & ~flush_i) | CALC | (DONE & ~ready_i). It is combinational, so the ID/EX register holds the op until the result is consumed.
- flush_i high in any state: next state IDLE, valid_o=0 the next cycle. flush_i overrides valid_i in IDLE.
- result_o holds its last value outside DONE. Consumers qualify it with valid_o.
- Reset asserted mid-CALC clears everything immediately. No result is produced after release.

Test Plan:
- MUL 7 * -3 (rs2=64'hFFFF_FFFF_FFFF_FFFD) -> valid_o 65 cycles after accept, result_o = 64'hFFFF_FFFF_FFFF_FFEB; busy_o high throughout CALC.
- MULHU 64'hFFFF_FFFF_FFFF_FFFF * 2 -> 64'h1; MULH same operands -> 64'hFFFF_FFFF_FFFF_FFFF; MULHSU rs1=-1, rs2=2 -> 64'hFFFF_FFFF_FFFF_FFFF.
- DIV -20 / 3 -> quotient 64'hFFFF_FFFF_FFFF_FFFA (-6); REM -20 / 3 -> 64'hFFFF_FFFF_FFFF_FFFE (-2); DIVU 20 / 3 -> 6.
- DIV x / 0 -> all ones after 1 cycle; REM 5 / 0 -> 5; DIV 64'h8000_0000_0000_0000 / -1 -> 64'h8000_0000_0000_0000; REM of the same -> 0.
- DIVUW rs1=64'h0000_0000_8000_0000, rs2=1 -> 64'hFFFF_FFFF_8000_0000 at 33 cycles; MULW 64'h1_0000_0002 * 3 -> 6.
- Boundary events:
  - flush_i asserted at CALC cycle 10 -> IDLE next cycle, no valid_o.
  - ready_i=0 for 5 cycles in DONE -> result_o stable and busy_o high until ready_i=1.
  - rst_n pulsed low mid-CALC -> outputs 0 immediately.
